// File: rtl/ref_fetch_addr_gen_pkg.sv
// Shared types and constants for the reference-fetch address generator.
package ref_fetch_addr_gen_pkg;

    localparam int COORD_W      = 16;
    localparam int BLK_SIZE_DEF = 4;
    localparam int TAPS_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    function automatic logic [COORD_W-1:0] sext15(input logic [14:0] v);
        return {{(COORD_W-15){v[14]}}, v};
    endfunction

endpackage

// File: rtl/ref_fetch_addr_gen_window_calc.sv
// Combinational reference window: top-left corner, row length and row count.
module ref_window_calc
    import ref_fetch_addr_gen_pkg::*;
#(
    parameter int BLK_SIZE = BLK_SIZE_DEF,
    parameter int TAPS     = TAPS_DEF
) (
    input  logic [7:0]         i_blk_x,
    input  logic [7:0]         i_blk_y,
    input  logic [14:0]        i_mv_x_int,
    input  logic [14:0]        i_mv_y_int,
    input  logic               i_interp_x,
    input  logic               i_interp_y,
    output logic [COORD_W-1:0] o_base_x,
    output logic [COORD_W-1:0] o_base_y,
    output logic [3:0]         o_len,
    output logic [3:0]         o_nrows
);

    localparam logic [COORD_W-1:0] MARGIN   = COORD_W'(TAPS/2 - 1);
    localparam logic [3:0]         SPAN_NOF = 4'(BLK_SIZE);
    localparam logic [3:0]         SPAN_FLT = 4'(BLK_SIZE + TAPS - 1);

    logic [COORD_W-1:0] w_margin_x, w_margin_y;

    assign w_margin_x = i_interp_x ? MARGIN : '0;
    assign w_margin_y = i_interp_y ? MARGIN : '0;

    // Modulo-2^16 arithmetic; out-of-range windows simply wrap.
    assign o_base_x = {{(COORD_W-8){1'b0}}, i_blk_x} + sext15(i_mv_x_int) - w_margin_x;
    assign o_base_y = {{(COORD_W-8){1'b0}}, i_blk_y} + sext15(i_mv_y_int) - w_margin_y;
    assign o_len    = i_interp_x ? SPAN_FLT : SPAN_NOF;
    assign o_nrows  = i_interp_y ? SPAN_FLT : SPAN_NOF;

endmodule

// File: rtl/ref_fetch_addr_gen.sv
// Turns one motion vector into a burst of row-read requests covering the
// filter support window of a sub-block.
module ref_fetch_addr_gen
    import ref_fetch_addr_gen_pkg::*;
#(
    parameter int BLK_SIZE = BLK_SIZE_DEF,
    parameter int TAPS     = TAPS_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MV_VALID,
    output logic                MV_READY,
    input  logic [14:0]         MV_X_INT,
    input  logic [14:0]         MV_Y_INT,
    input  logic [3:0]          MV_X_FRAC,
    input  logic [3:0]          MV_Y_FRAC,
    input  logic                INTERP_X,
    input  logic                INTERP_Y,
    input  logic [7:0]          BLK_X,
    input  logic [7:0]          BLK_Y,
    output logic                RD_VALID,
    input  logic                RD_READY,
    output logic [COORD_W-1:0]  RD_X,
    output logic [COORD_W-1:0]  RD_Y,
    output logic [3:0]          RD_LEN,
    output logic [3:0]          FILT_X_FRAC,
    output logic [3:0]          FILT_Y_FRAC,
    output logic                FETCH_DONE
);

    fetch_state_t       r_state, w_state_nxt;
    logic [COORD_W-1:0] r_base_x, r_base_y;
    logic [3:0]         r_len, r_nrows, r_row;
    logic [3:0]         r_fx, r_fy;

    logic [COORD_W-1:0] w_base_x, w_base_y;
    logic [3:0]         w_len, w_nrows;
    logic               w_capture, w_row_acc;

    ref_window_calc #(
        .BLK_SIZE (BLK_SIZE),
        .TAPS     (TAPS)
    ) u_window (
        .i_blk_x    (BLK_X),
        .i_blk_y    (BLK_Y),
        .i_mv_x_int (MV_X_INT),
        .i_mv_y_int (MV_Y_INT),
        .i_interp_x (INTERP_X),
        .i_interp_y (INTERP_Y),
        .o_base_x   (w_base_x),
        .o_base_y   (w_base_y),
        .o_len      (w_len),
        .o_nrows    (w_nrows)
    );

    always_comb begin
        w_state_nxt = r_state;
        MV_READY    = 1'b0;
        RD_VALID    = 1'b0;
        FETCH_DONE  = 1'b0;
        w_capture   = 1'b0;
        w_row_acc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                MV_READY = 1'b1;
                if (MV_VALID) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                RD_VALID = 1'b1;
                if (RD_READY) begin
                    w_row_acc = 1'b1;
                    if (r_row == r_nrows - 4'd1)
                        w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                FETCH_DONE  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_base_x <= '0;
            r_base_y <= '0;
            r_len    <= '0;
            r_nrows  <= '0;
            r_row    <= '0;
            r_fx     <= '0;
            r_fy     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_base_x <= w_base_x;
                r_base_y <= w_base_y;
                r_len    <= w_len;
                r_nrows  <= w_nrows;
                r_row    <= '0;
                r_fx     <= MV_X_FRAC;
                r_fy     <= MV_Y_FRAC;
            end else if (w_row_acc) begin
                r_row <= r_row + 4'd1;
            end
        end
    end

    // Address only advances on handshake, so it is stable across stalls.
    assign RD_X        = r_base_x;
    assign RD_Y        = r_base_y + {{(COORD_W-4){1'b0}}, r_row};
    assign RD_LEN      = r_len;
    assign FILT_X_FRAC = r_fx;
    assign FILT_Y_FRAC = r_fy;

endmodule

// File: tb/tb_ref_fetch_addr_gen.sv
// Vector table plus scoreboard of expected row requests for ref_fetch_addr_gen.
module tb_ref_fetch_addr_gen;

    logic        CLK = 1'b0;
    logic        RST, MV_VALID, MV_READY, INTERP_X, INTERP_Y;
    logic [14:0] MV_X_INT, MV_Y_INT;
    logic [3:0]  MV_X_FRAC, MV_Y_FRAC, RD_LEN, FILT_X_FRAC, FILT_Y_FRAC;
    logic [7:0]  BLK_X, BLK_Y;
    logic        RD_VALID, RD_READY, FETCH_DONE;
    logic [15:0] RD_X, RD_Y;

    always #5 CLK = ~CLK;

    ref_fetch_addr_gen dut (
        .CLK(CLK), .RST(RST), .MV_VALID(MV_VALID), .MV_READY(MV_READY),
        .MV_X_INT(MV_X_INT), .MV_Y_INT(MV_Y_INT), .MV_X_FRAC(MV_X_FRAC), .MV_Y_FRAC(MV_Y_FRAC),
        .INTERP_X(INTERP_X), .INTERP_Y(INTERP_Y), .BLK_X(BLK_X), .BLK_Y(BLK_Y),
        .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_X(RD_X), .RD_Y(RD_Y), .RD_LEN(RD_LEN),
        .FILT_X_FRAC(FILT_X_FRAC), .FILT_Y_FRAC(FILT_Y_FRAC), .FETCH_DONE(FETCH_DONE)
    );

    typedef struct {
        logic [7:0]         bx, by;
        logic signed [14:0] mx, my;
        logic [3:0]         fx, fy;
        logic               ix, iy;
        int                 rmode;   // 0 always ready, 1 toggle, 2 random
        int                 inject;  // pulse a second MV mid-fetch
        logic signed [15:0] ex, ey;
        logic [3:0]         elen;
        int                 en;
    } vec_t;

    typedef struct {
        logic [15:0] x, y;
        logic [3:0]  len;
    } row_t;

    row_t exp_q[$];
    vec_t vecs[5];
    int   checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mv_ready"}, 32'(MV_READY), 1);
        chk({tag, "_rd_valid"}, 32'(RD_VALID), 0);
        chk({tag, "_rd_x"}, 32'(RD_X), 0);
        chk({tag, "_rd_y"}, 32'(RD_Y), 0);
        chk({tag, "_rd_len"}, 32'(RD_LEN), 0);
        chk({tag, "_filt_x"}, 32'(FILT_X_FRAC), 0);
        chk({tag, "_filt_y"}, 32'(FILT_Y_FRAC), 0);
        chk({tag, "_done"}, 32'(FETCH_DONE), 0);
    endtask

    task automatic run_fetch(input vec_t v, input int rst_after);
        int   cyc, acc, stalls;
        logic done_seen;
        row_t e;
        @(negedge CLK);
        chk("mv_ready_idle", 32'(MV_READY), 1);
        BLK_X = v.bx; BLK_Y = v.by; MV_X_INT = v.mx; MV_Y_INT = v.my;
        MV_X_FRAC = v.fx; MV_Y_FRAC = v.fy; INTERP_X = v.ix; INTERP_Y = v.iy;
        MV_VALID = 1'b1;
        for (int r = 0; r < v.en; r++) begin
            e.x = v.ex; e.y = 16'(v.ey + 16'(r)); e.len = v.elen;
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1 MV_VALID = 1'b0;
        cyc = 0; acc = 0; stalls = 0; done_seen = 1'b0;
        while (!done_seen && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            if (rst_after > 0 && acc == rst_after) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
                chk_reset_outputs("mid_rst");
                @(negedge CLK);
                chk("mid_rst_no_done", 32'(FETCH_DONE), 0);
                chk("mid_rst_idle_ready", 32'(MV_READY), 1);
                exp_q.delete();
                return;
            end
            case (v.rmode)
                0:       RD_READY = 1'b1;
                1:       RD_READY = cyc[0];
                default: RD_READY = 1'($urandom_range(0, 1));
            endcase
            if (v.inject != 0 && cyc == 2) begin
                MV_VALID = 1'b1; MV_X_INT = 15'sd100; MV_Y_INT = -15'sd50;
                BLK_X = 8'd7; INTERP_X = ~v.ix; MV_X_FRAC = 4'd1;
            end else begin
                MV_VALID = 1'b0;
            end
            if (FETCH_DONE) begin
                done_seen = 1'b1;
                chk("done_cycle", 32'(cyc), 32'(v.en + 1 + stalls));
                chk("rows_accepted", 32'(acc), 32'(v.en));
                chk("done_no_valid", 32'(RD_VALID), 0);
                chk("done_no_ready", 32'(MV_READY), 0);
                chk("filt_x", 32'(FILT_X_FRAC), 32'(v.fx));
                chk("filt_y", 32'(FILT_Y_FRAC), 32'(v.fy));
            end else if (!RD_VALID) begin
                chk("rd_valid_missing", 32'(RD_VALID), 1);
            end else begin
                chk("busy_mv_ready", 32'(MV_READY), 0);
                if (exp_q.size() == 0) begin
                    chk("extra_row", 32'(exp_q.size()), 1);
                end else if (RD_READY) begin
                    e = exp_q.pop_front();
                    chk("rd_x", 32'(RD_X), 32'(e.x));
                    chk("rd_y", 32'(RD_Y), 32'(e.y));
                    chk("rd_len", 32'(RD_LEN), 32'(e.len));
                    acc++;
                end else begin
                    stalls++;
                    chk("stall_x", 32'(RD_X), 32'(exp_q[0].x));
                    chk("stall_y", 32'(RD_Y), 32'(exp_q[0].y));
                end
            end
        end
        MV_VALID = 1'b0;
        if (!done_seen) chk("done_timeout", 0, 1);
        chk("queue_drained", 32'(exp_q.size()), 0);
        exp_q.delete();
        @(negedge CLK);
        chk("done_one_cycle", 32'(FETCH_DONE), 0);
        chk("back_idle_ready", 32'(MV_READY), 1);
        chk("filt_hold_x", 32'(FILT_X_FRAC), 32'(v.fx));
    endtask

    initial begin
        //          bx     by     mx          my          fx    fy    ix    iy   rm inj ex             ey           len    n
        vecs[0] = '{8'd8,  8'd4,  15'sd2,     -15'sd1,    4'd0, 4'd0, 1'b0, 1'b0, 0, 0, 16'sd10,     16'sd3,     4'd4,  4};
        vecs[1] = '{8'd0,  8'd0,  15'sd0,     15'sd0,     4'd8, 4'd4, 1'b1, 1'b1, 0, 1, -16'sd3,     -16'sd3,    4'd11, 11};
        vecs[2] = '{8'd20, 8'd30, -15'sd5,    15'sd7,     4'd3, 4'd0, 1'b1, 1'b0, 1, 0, 16'sd12,     16'sd37,    4'd11, 4};
        vecs[3] = '{8'd0,  8'd255,-15'sd16384,15'sd16383, 4'd15,4'd15,1'b1, 1'b0, 0, 0, -16'sd16387, 16'sd16638, 4'd11, 4};
        vecs[4] = '{8'd255,8'd255,-15'sd1,    -15'sd2,    4'd1, 4'd2, 1'b0, 1'b1, 2, 0, 16'sd254,    16'sd250,   4'd4,  11};

        RST = 1'b1; MV_VALID = 1'b0; RD_READY = 1'b0;
        MV_X_INT = '0; MV_Y_INT = '0; MV_X_FRAC = '0; MV_Y_FRAC = '0;
        INTERP_X = 1'b0; INTERP_Y = 1'b0; BLK_X = '0; BLK_Y = '0;
        repeat (2) @(negedge CLK);
        chk_reset_outputs("reset");
        RST = 1'b0;

        for (int i = 0; i < 5; i++) run_fetch(vecs[i], 0);

        // Reset lands while the third row is being presented.
        run_fetch(vecs[0], 2);
        run_fetch(vecs[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ref_fetch_addr_gen.md
REF_FETCH_ADDR_GEN -- requirements
Module: ref_fetch_addr_gen

Interface
REQ-001 SHALL have parameter BLK_SIZE, default 4, sub-block edge in samples.
REQ-002 SHALL have parameter TAPS, default 8, luma interpolation filter length.
REQ-003 SHALL have port CLK, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port MV_VALID, input, 1, generated-MV available.
REQ-006 SHALL have port MV_READY, output, 1, block accepts a new MV.
REQ-007 SHALL have port MV_X_INT, input, 15, signed integer horizontal MV.
REQ-008 SHALL have port MV_Y_INT, input, 15, signed integer vertical MV.
REQ-009 SHALL have port MV_X_FRAC, input, 4, 1/16-sample horizontal phase.
REQ-010 SHALL have port MV_Y_FRAC, input, 4, 1/16-sample vertical phase.
REQ-011 SHALL have port INTERP_X, input, 1, horizontal filtering needed.
REQ-012 SHALL have port INTERP_Y, input, 1, vertical filtering needed.
REQ-013 SHALL have port BLK_X, input, 8, unsigned sub-block left position.
REQ-014 SHALL have port BLK_Y, input, 8, unsigned sub-block top position.
REQ-015 SHALL have port RD_VALID, output, 1, row-read request valid.
REQ-016 SHALL have port RD_READY, input, 1, reference memory accepts request.
REQ-017 SHALL have port RD_X, output, 16, signed leftmost sample column of row.
REQ-018 SHALL have port RD_Y, output, 16, signed row coordinate.
REQ-019 SHALL have port RD_LEN, output, 4, samples per row.
REQ-020 SHALL have port FILT_X_FRAC, output, 4, registered horizontal phase for filter.
REQ-021 SHALL have port FILT_Y_FRAC, output, 4, registered vertical phase for filter.
REQ-022 SHALL have port FETCH_DONE, output, 1, one-cycle pulse after last row accepted.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, DONE.
REQ-024 IDLE: MV_READY=1, RD_VALID=0; MV_VALID=1 captures all MV/BLK/INTERP inputs, go ISSUE next cycle.
REQ-025 Capture: MARGIN_X = INTERP_X ? TAPS/2-1 (3) : 0; EXT_X = INTERP_X ? TAPS-1 (7) : 0; likewise Y.
REQ-026 Base column = sign-extend(BLK_X zero-extended) + sign-extend(MV_X_INT) - MARGIN_X, 16-bit two's complement, wrap on overflow; same for base row.
REQ-027 RD_LEN = BLK_SIZE + EXT_X (4 or 11); row count N = BLK_SIZE + EXT_Y (4 or 11).
REQ-028 ISSUE: RD_VALID=1, RD_X=base column, RD_Y=base row + row counter; MV_READY=0.
REQ-029 RD_X/RD_Y/RD_LEN SHALL stay stable while RD_VALID=1 and RD_READY=0.
REQ-030 On RD_VALID&RD_READY, row counter increments; on row N-1 accepted, go DONE.
REQ-031 Throughput: one row per cycle when RD_READY held high; first request one cycle after MV handshake.
REQ-032 DONE: FETCH_DONE=1 for exactly one cycle, RD_VALID=0, MV_READY=0; then IDLE.
REQ-033 FILT_X_FRAC/FILT_Y_FRAC SHALL update at capture and hold until next capture.
REQ-034 MV_VALID outside IDLE SHALL be ignored (no capture, no state change).

Reset
REQ-035 RST=1 at a clock edge SHALL force IDLE, row counter 0, all captured registers 0.
REQ-036 Outputs during/after reset: MV_READY=1, RD_VALID=0, RD_X=0, RD_Y=0, RD_LEN=0, FILT_*_FRAC=0, FETCH_DONE=0.
REQ-037 RST asserted mid-ISSUE SHALL drop RD_VALID next cycle with no FETCH_DONE; pending fetch discarded.

Structure
REQ-038 Shared package SHALL hold FSM state type, BLK_SIZE/TAPS defaults, and 16-bit coordinate width constant.
REQ-039 One sub-module natural: ref_window_calc (combinational base/length/row-count computation).

Verification
REQ-040 BLK=(8,4), MV_INT=(2,-1), INTERP=00, RD_READY=1 -> 4 requests, RD_X=10, RD_Y=3..6, RD_LEN=4, FETCH_DONE on cycle 6.
REQ-041 BLK=(0,0), MV_INT=(0,0), INTERP=11, FRAC=(8,4) -> 11 requests, RD_X=-3, RD_Y=-3..7, RD_LEN=11, FILT frac=(8,4).
REQ-042 RD_READY toggled 1/0 each cycle during fetch -> each row address held while stalled, no rows skipped or duplicated.
REQ-043 MV_VALID pulsed during ISSUE with different MV -> ignored; addresses follow first MV.
REQ-044 RST asserted after 2nd accepted row -> RD_VALID=0 next cycle, no FETCH_DONE, MV_READY=1, next MV fetched correctly.
REQ-045 MV_X_INT=-16384, BLK_X=0, INTERP_X=1 -> RD_X=-16387, correct sign extension.
